viewport_scaler_pipe: RTL and testbench



---
 rtl/viewport_scaler_pipe.sv | 153 +++++++++++++++
 tb/tb_viewport_scaler_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/viewport_scaler_pipe.sv
// Pipelined per-vertex viewport scaler: one primitive per handshake, vertices walked
// one per cycle through a shared X/Y multiplier pair, result returned as one bundle.
module viewport_scaler_pipe #(
  parameter int DATA_W  = 21,
  parameter int SCALE_W = 21,
  parameter int FRAC_W  = 18,
  parameter int NUM_VTX = 4,
  parameter int ROUND   = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_VTX*3*DATA_W-1:0] in_vtx,
  input  logic [SCALE_W-1:0]          scale_x,
  input  logic [SCALE_W-1:0]          scale_y,
  input  logic [DATA_W-1:0]           off_x,
  input  logic [DATA_W-1:0]           off_y,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_VTX*3*DATA_W-1:0] out_vtx,
  output logic                        out_sat
);

  localparam int VW = 3 * DATA_W;
  localparam int PW = DATA_W + SCALE_W;
  localparam int SW = PW + 1;
  localparam int IW = $clog2(NUM_VTX + 1);

  localparam logic signed [SW-1:0] MAXV = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [SW-1:0] RND  = {{(SW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, nstate;
  logic   armed;

  logic [NUM_VTX*VW-1:0]      vtx_q;
  logic signed [SCALE_W-1:0]  sx_q, sy_q;
  logic signed [DATA_W-1:0]   ox_q, oy_q;
  logic [IW-1:0]              idx, s1_idx;
  logic                       s1_valid;
  logic signed [PW-1:0]       s1_px, s1_py;
  logic [DATA_W-1:0]          s1_z;

  logic [VW-1:0]              cur;
  logic signed [DATA_W-1:0]   cur_x, cur_y;
  logic signed [PW-1:0]       mul_x, mul_y;
  logic                       issue, accept, s1_last;
  logic [DATA_W-1:0]          res_x, res_y;
  logic                       sat_x, sat_y;

  // Shift, offset and clamp one product; MSB of the result flags a clamp.
  function automatic logic [DATA_W:0] post(input logic signed [PW-1:0] p,
                                           input logic signed [DATA_W-1:0] off);
    logic signed [SW-1:0] t;
    t = {p[PW-1], p};
    if (ROUND != 0) t = t + RND;
    t = t >>> FRAC_W;
    t = t + {{(SW-DATA_W){off[DATA_W-1]}}, off};
    if (t > MAXV) return {1'b1, MAXV[DATA_W-1:0]};
    if (t < MINV) return {1'b1, MINV[DATA_W-1:0]};
    return {1'b0, t[DATA_W-1:0]};
  endfunction

  always_comb begin
    nstate   = state;
    in_ready = armed && (state == IDLE);
    case (state)
      IDLE:    if (in_valid && in_ready) nstate = RUN;
      RUN:     if (s1_valid && s1_last) nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign accept  = in_valid && in_ready;
  assign issue   = (state == RUN) && (idx != IW'(NUM_VTX));
  assign s1_last = (s1_idx == IW'(NUM_VTX - 1));

  always_comb begin
    cur = '0;
    for (int unsigned k = 0; k < NUM_VTX; k++)
      if (idx == IW'(k)) cur = vtx_q[k*VW +: VW];
  end

  assign cur_x = cur[DATA_W-1:0];
  assign cur_y = cur[2*DATA_W-1:DATA_W];
  assign mul_x = PW'(cur_x) * PW'(sx_q);
  assign mul_y = PW'(cur_y) * PW'(sy_q);

  always_comb begin
    {sat_x, res_x} = post(s1_px, ox_q);
    {sat_y, res_y} = post(s1_py, oy_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      vtx_q     <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      idx       <= '0;
      s1_valid  <= 1'b0;
      s1_idx    <= '0;
      s1_px     <= '0;
      s1_py     <= '0;
      s1_z      <= '0;
      out_vtx   <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        vtx_q   <= in_vtx;
        sx_q    <= scale_x;
        sy_q    <= scale_y;
        ox_q    <= off_x;
        oy_q    <= off_y;
        idx     <= '0;
        out_sat <= 1'b0;
      end else if (issue) begin
        idx <= idx + IW'(1);
      end

      s1_valid <= issue;
      if (issue) begin
        s1_px  <= mul_x;
        s1_py  <= mul_y;
        s1_z   <= cur[VW-1:2*DATA_W];
        s1_idx <= idx;
      end

      if (s1_valid) begin
        for (int unsigned k = 0; k < NUM_VTX; k++)
          if (s1_idx == IW'(k)) out_vtx[k*VW +: VW] <= {s1_z, res_y, res_x};
        out_sat <= out_sat | sat_x | sat_y;
        if (s1_last) out_valid <= 1'b1;
      end

      if ((state == DONE) && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_viewport_scaler_pipe.sv
// Directed bench for viewport_scaler_pipe: truncating and rounding instances share stimulus.
module tb_viewport_scaler_pipe;

  localparam int DW = 21;
  localparam int NV = 4;
  localparam int BW = NV * 3 * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, out_ready;
  logic [BW-1:0] in_vtx;
  logic [DW-1:0] scale_x, scale_y, off_x, off_y;
  logic          in_ready0, in_ready1, out_valid0, out_valid1, out_sat0, out_sat1;
  logic [BW-1:0] out_vtx0, out_vtx1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  viewport_scaler_pipe #(.DATA_W(21), .SCALE_W(21), .FRAC_W(18), .NUM_VTX(NV), .ROUND(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_vtx(in_vtx),
    .scale_x(scale_x), .scale_y(scale_y), .off_x(off_x), .off_y(off_y),
    .out_valid(out_valid0), .out_ready(out_ready), .out_vtx(out_vtx0), .out_sat(out_sat0));

  viewport_scaler_pipe #(.DATA_W(21), .SCALE_W(21), .FRAC_W(18), .NUM_VTX(NV), .ROUND(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_vtx(in_vtx),
    .scale_x(scale_x), .scale_y(scale_y), .off_x(off_x), .off_y(off_y),
    .out_valid(out_valid1), .out_ready(out_ready), .out_vtx(out_vtx1), .out_sat(out_sat1));

  // Packed vertex arrays: element [k] is vertex k.
  typedef struct {
    logic [NV-1:0][DW-1:0] x, y, z;
    logic [DW-1:0]         sx, sy, ox, oy;
    logic [NV-1:0][DW-1:0] ex0, ex1, ey0, ey1;
    logic                  sat;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack_in(input vec_t v);
    logic [BW-1:0] b;
    for (int k = 0; k < NV; k++) b[k*3*DW +: 3*DW] = {v.z[k], v.y[k], v.x[k]};
    return b;
  endfunction

  function automatic logic [BW-1:0] exp_bundle(input vec_t v, input int r);
    logic [BW-1:0] b;
    for (int k = 0; k < NV; k++)
      b[k*3*DW +: 3*DW] = (r != 0) ? {v.z[k], v.ey1[k], v.ex1[k]} : {v.z[k], v.ey0[k], v.ex0[k]};
    return b;
  endfunction

  // Present a primitive, wait for acceptance, then scramble the config inputs.
  task automatic send(input vec_t v);
    int n;
    in_vtx   = pack_in(v);
    scale_x  = v.sx;
    scale_y  = v.sy;
    off_x    = v.ox;
    off_y    = v.oy;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_wait", (n < 50), 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_vtx   = '1;
    scale_x  = 21'h1FFFFF;
    scale_y  = 21'h000000;
    off_x    = 21'h0AAAA;
    off_y    = 21'h15555;
  endtask

  task automatic wait_out(input int id);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid0 && n < 50);
    chk($sformatf("t%0d.latency", id), n, NV + 1);
    chk($sformatf("t%0d.out_valid_r1", id), out_valid1, 1'b1);
  endtask

  task automatic check_result(input vec_t v, input int id);
    logic [3*DW-1:0] s0, s1;
    for (int k = 0; k < NV; k++) begin
      s0 = out_vtx0[k*3*DW +: 3*DW];
      s1 = out_vtx1[k*3*DW +: 3*DW];
      chk($sformatf("t%0d.v%0d.x_r0", id, k), s0[DW-1:0], v.ex0[k]);
      chk($sformatf("t%0d.v%0d.x_r1", id, k), s1[DW-1:0], v.ex1[k]);
      chk($sformatf("t%0d.v%0d.y_r0", id, k), s0[2*DW-1:DW], v.ey0[k]);
      chk($sformatf("t%0d.v%0d.y_r1", id, k), s1[2*DW-1:DW], v.ey1[k]);
      chk($sformatf("t%0d.v%0d.z_r0", id, k), s0[3*DW-1:2*DW], v.z[k]);
      chk($sformatf("t%0d.v%0d.z_r1", id, k), s1[3*DW-1:2*DW], v.z[k]);
    end
    chk($sformatf("t%0d.sat_r0", id), out_sat0, v.sat);
    chk($sformatf("t%0d.sat_r1", id), out_sat1, v.sat);
  endtask

  task automatic release_out(input int id);
    chk($sformatf("t%0d.in_ready_done", id), in_ready0, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk($sformatf("t%0d.out_valid_clr", id), out_valid0, 1'b0);
    chk($sformatf("t%0d.in_ready_back_r0", id), in_ready0, 1'b1);
    chk($sformatf("t%0d.in_ready_back_r1", id), in_ready1, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    send(v);
    wait_out(id);
    check_result(v, id);
    release_out(id);
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_vtx    = '0;
    scale_x   = 21'h50000;
    scale_y   = 21'h3C000;
    off_x     = '0;
    off_y     = '0;

    for (int i = 0; i < 8; i++) begin
      tbl[i].sx  = 21'h50000;
      tbl[i].sy  = 21'h3C000;
      tbl[i].ox  = '0;
      tbl[i].oy  = '0;
      tbl[i].x   = '0;
      tbl[i].y   = '0;
      tbl[i].z   = '0;
      tbl[i].ex0 = '0;
      tbl[i].ex1 = '0;
      tbl[i].ey0 = '0;
      tbl[i].ey1 = '0;
      tbl[i].sat = 1'b0;
    end
    // Concatenations below list vertex 3 first, vertex 0 last.
    // 0: default scales, unity coordinates
    tbl[0].x   = {4{21'h40000}};  tbl[0].y   = {4{21'h40000}};  tbl[0].z = {4{21'h12345}};
    tbl[0].ex0 = {4{21'h50000}};  tbl[0].ex1 = {4{21'h50000}};
    tbl[0].ey0 = {4{21'h3C000}};  tbl[0].ey1 = {4{21'h3C000}};
    // 1: truncation vs rounding on small X
    tbl[1].x   = {21'h000000, 21'h1FFFFC, 21'h1FFFFF, 21'h000001};
    tbl[1].z   = {21'h1FFFFF, 21'h000000, 21'h0ABCD, 21'h1ABCD};
    tbl[1].ex0 = {21'h000000, 21'h1FFFFB, 21'h1FFFFE, 21'h000001};
    tbl[1].ex1 = {21'h000000, 21'h1FFFFB, 21'h1FFFFF, 21'h000001};
    // 2: positive clamp
    tbl[2].x   = {4{21'h0FFFFF}};
    tbl[2].ex0 = {4{21'h0FFFFF}}; tbl[2].ex1 = {4{21'h0FFFFF}}; tbl[2].sat = 1'b1;
    // 3: negative clamp
    tbl[3].x   = {4{21'h100000}};
    tbl[3].ex0 = {4{21'h100000}}; tbl[3].ex1 = {4{21'h100000}}; tbl[3].sat = 1'b1;
    // 4: clean primitive after clamps
    tbl[4].x   = {4{21'h40000}};  tbl[4].y   = {4{21'h40000}};
    tbl[4].z   = {21'h04444, 21'h33333, 21'h22222, 21'h11111};
    tbl[4].ex0 = {4{21'h50000}};  tbl[4].ex1 = {4{21'h50000}};
    tbl[4].ey0 = {4{21'h3C000}};  tbl[4].ey1 = {4{21'h3C000}};
    // 5: signed offsets
    tbl[5].ox  = 21'h1FFFF6;      tbl[5].oy  = 21'h000007;
    tbl[5].x   = {4{21'h40000}};  tbl[5].y   = {4{21'h40000}};  tbl[5].z = {4{21'h0ABCD}};
    tbl[5].ex0 = {4{21'h4FFF6}};  tbl[5].ex1 = {4{21'h4FFF6}};
    tbl[5].ey0 = {4{21'h3C007}};  tbl[5].ey1 = {4{21'h3C007}};
    // 6: offset-driven clamp on X, x2 scale clamps on Y
    tbl[6].sx  = 21'h40000;       tbl[6].sy  = 21'h80000;       tbl[6].ox = 21'h000001;
    tbl[6].x   = {21'h1FFFFF, 21'h000000, 21'h0FFFFF, 21'h0FFFFE};
    tbl[6].y   = {21'h000003, 21'h100000, 21'h0FFFFF, 21'h000000};
    tbl[6].z   = {21'h00004, 21'h00003, 21'h00002, 21'h00001};
    tbl[6].ex0 = {21'h000000, 21'h000001, 21'h0FFFFF, 21'h0FFFFF};
    tbl[6].ex1 = {21'h000000, 21'h000001, 21'h0FFFFF, 21'h0FFFFF};
    tbl[6].ey0 = {21'h000006, 21'h100000, 21'h0FFFFF, 21'h000000};
    tbl[6].ey1 = {21'h000006, 21'h100000, 21'h0FFFFF, 21'h000000};
    tbl[6].sat = 1'b1;
    // 7: negative X scale, half Y scale with rounding differences
    tbl[7].sx  = 21'h1C0000;      tbl[7].sy  = 21'h20000;
    tbl[7].x   = {21'h000000, 21'h000064, 21'h1FFFF9, 21'h000005};
    tbl[7].y   = {21'h000000, 21'h000004, 21'h1FFFFD, 21'h000003};
    tbl[7].z   = {21'h15555, 21'h0AAAA, 21'h1F0F0, 21'h00F0F};
    tbl[7].ex0 = {21'h000000, 21'h1FFF9C, 21'h000007, 21'h1FFFFB};
    tbl[7].ex1 = {21'h000000, 21'h1FFF9C, 21'h000007, 21'h1FFFFB};
    tbl[7].ey0 = {21'h000000, 21'h000002, 21'h1FFFFE, 21'h000001};
    tbl[7].ey1 = {21'h000000, 21'h000002, 21'h1FFFFF, 21'h000002};

    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", in_ready0, 1'b0);
    chk("rst.out_valid", out_valid0, 1'b0);
    chk("rst.out_vtx", out_vtx0, '0);
    chk("rst.out_sat", out_sat0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

    // Backpressure: result held, new request ignored while DONE.
    send(tbl[5]);
    wait_out(20);
    check_result(tbl[5], 20);
    in_vtx   = pack_in(tbl[0]);
    scale_x  = 21'h40000;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d.out_valid", c), out_valid0, 1'b1);
      chk($sformatf("hold%0d.out_vtx", c), out_vtx0, exp_bundle(tbl[5], 0));
      chk($sformatf("hold%0d.in_ready", c), in_ready0, 1'b0);
    end
    in_valid = 1'b0;
    release_out(20);
    repeat (3) @(posedge clk);
    #1;
    chk("hold.no_extra_out", out_valid0, 1'b0);

    // Reset in the middle of RUN.
    send(tbl[3]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid_r0", out_valid0, 1'b0);
    chk("midrst.out_valid_r1", out_valid1, 1'b0);
    chk("midrst.out_vtx", out_vtx0, '0);
    chk("midrst.out_sat", out_sat0, 1'b0);
    chk("midrst.in_ready", in_ready0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_vec(tbl[4], 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
